// File: rtl/vga_bus_slave_pkg.sv
// vga_bus_slave_pkg: register offsets, reset colour and FIFO entry layout for the VGA bus slave.
package vga_bus_slave_pkg;
    localparam logic [7:0] REG_X      = 8'd0;
    localparam logic [7:0] REG_Y      = 8'd1;
    localparam logic [7:0] REG_PIX    = 8'd2;
    localparam logic [7:0] REG_COL_LO = 8'd3;
    localparam logic [7:0] REG_COL_HI = 8'd4;
    localparam logic [15:0] CONFIG_COL_RST = 16'hFF00;
    localparam int FB_ADDR_W = 15;
    typedef struct packed {
        logic [6:0] y;
        logic [7:0] x;
        logic       pix;
    } fb_entry_t;
    function automatic logic in_window(input logic [7:0] addr, input logic [7:0] base);
        return addr >= base && 8'(addr - base) < 8'd5;
    endfunction
endpackage

// File: rtl/vga_wr_fifo.sv
// vga_wr_fifo: synchronous FIFO with level count; a push into a full FIFO is taken when a pop shares the edge.
module vga_wr_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic push_ok, pop_ok;
    assign empty   = level == '0;
    assign full    = level == (AW+1)'(DEPTH);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rp];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wp] <= din;
                wp      <= wp + AW'(1);
            end
            if (pop_ok) rp <= rp + AW'(1);
            level <= level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
endmodule

// File: rtl/vga_bus_slave.sv
// vga_bus_slave: VGA register window decode, X/Y/colour registers and pixel-write queue to the frame buffer.
// Define VGA_BUS_AUTOINC_EN to advance X/Y after every in-range pixel write.
import vga_bus_slave_pkg::*;
module vga_bus_slave #(
    parameter logic [7:0] BASE_ADDR  = 8'hB0,
    parameter int         H_PIX      = 160,
    parameter int         V_PIX      = 120,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [7:0]                  BUS_ADDR,
    input  logic [7:0]                  BUS_DATA,
    input  logic                        BUS_WE,
    output logic                        FB_VALID,
    input  logic                        FB_READY,
    output logic [FB_ADDR_W-1:0]        FB_ADDR,
    output logic                        FB_DATA,
    output logic [15:0]                 CONFIG_COL,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
    output logic                        OVERFLOW
);
    localparam logic [7:0] X_LIM = 8'(H_PIX);
    localparam logic [7:0] X_MAX = 8'(H_PIX - 1);
    localparam logic [6:0] Y_LIM = 7'(V_PIX);
    localparam logic [6:0] Y_MAX = 7'(V_PIX - 1);
    logic [7:0] x, off;
    logic [6:0] y;
    logic hit, pix_req, push, pop, full, empty;
    fb_entry_t wr_ent, head;
    assign off     = BUS_ADDR - BASE_ADDR;
    assign hit     = BUS_WE && in_window(BUS_ADDR, BASE_ADDR);
    assign pix_req = hit && off == REG_PIX && x < X_LIM && y < Y_LIM;
    assign pop     = !empty && FB_READY;
    assign push    = pix_req && (!full || pop);
    assign wr_ent  = '{y, x, BUS_DATA[0]};
    vga_wr_fifo #(.WIDTH($bits(fb_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push),
        .pop   (pop),
        .din   (wr_ent),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (FIFO_LEVEL)
    );
    // Head outputs read as zero while empty so stale entries never show.
    assign FB_VALID = !empty;
    assign FB_ADDR  = empty ? '0 : {head.y, head.x};
    assign FB_DATA  = !empty && head.pix;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            x          <= '0;
            y          <= '0;
            CONFIG_COL <= CONFIG_COL_RST;
            OVERFLOW   <= 1'b0;
        end else begin
            if (hit && off == REG_X) x <= BUS_DATA;
            if (hit && off == REG_Y) y <= BUS_DATA[6:0];
            if (hit && off == REG_COL_LO) CONFIG_COL[7:0] <= BUS_DATA;
            if (hit && off == REG_COL_HI) CONFIG_COL[15:8] <= BUS_DATA;
            if (pix_req && !push) OVERFLOW <= 1'b1;
`ifdef VGA_BUS_AUTOINC_EN
            if (pix_req) begin
                x <= (x == X_MAX) ? '0 : x + 8'd1;
                if (x == X_MAX) y <= (y == Y_MAX) ? '0 : y + 7'd1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_vga_bus_slave.sv
// tb_vga_bus_slave: directed stimulus with a queue scoreboard; a negedge monitor checks every frame-buffer handshake.
module tb_vga_bus_slave;
    logic        CLK, RESET, BUS_WE, FB_VALID, FB_READY, FB_DATA, OVERFLOW;
    logic [7:0]  BUS_ADDR, BUS_DATA;
    logic [14:0] FB_ADDR;
    logic [15:0] CONFIG_COL;
    logic [2:0]  FIFO_LEVEL;
    logic [15:0] q[$];
    logic [7:0]  mx;
    logic [6:0]  my;
    int checks = 0;
    int failures = 0;

    vga_bus_slave dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .BUS_ADDR   (BUS_ADDR),
        .BUS_DATA   (BUS_DATA),
        .BUS_WE     (BUS_WE),
        .FB_VALID   (FB_VALID),
        .FB_READY   (FB_READY),
        .FB_ADDR    (FB_ADDR),
        .FB_DATA    (FB_DATA),
        .CONFIG_COL (CONFIG_COL),
        .FIFO_LEVEL (FIFO_LEVEL),
        .OVERFLOW   (OVERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // Monitor: every handshake must match the oldest expected entry.
    always @(negedge CLK) begin
        if (!RESET && FB_VALID && FB_READY) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop: got addr %0h data %0b expected none", FB_ADDR, FB_DATA);
            end else begin
                logic [15:0] e;
                e = q.pop_front();
                chk("fb_addr", {17'd0, FB_ADDR}, {17'd0, e[15:1]});
                chk("fb_data", {31'd0, FB_DATA}, {31'd0, e[0]});
            end
        end
    end

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(posedge CLK); #1;
        BUS_WE = 1'b1; BUS_ADDR = a; BUS_DATA = d;
        @(posedge CLK); #1;
        BUS_WE = 1'b0;
    endtask

    task automatic wx(input logic [7:0] d);
        wr(8'hB0, d);
        mx = d;
    endtask

    task automatic wy(input logic [7:0] d);
        wr(8'hB1, d);
        my = d[6:0];
    endtask

    task automatic inc(input bit inr);
`ifdef VGA_BUS_AUTOINC_EN
        if (inr) begin
            if (mx == 8'd159) begin
                mx = 8'd0;
                my = (my == 7'd119) ? 7'd0 : my + 7'd1;
            end else mx = mx + 8'd1;
        end
`else
        if (inr) mx = mx;
`endif
    endtask

    task automatic pix(input logic d, input bit acc);
        bit inr;
        inr = mx < 8'd160 && my < 7'd120;
        if (inr && acc) q.push_back({my, mx, d});
        wr(8'hB2, {7'd0, d});
        inc(inr);
    endtask

    task automatic fill4();
        for (int i = 0; i < 4; i++) begin
            wx(8'(10 + i));
            pix(i[0], 1'b1);
        end
    endtask

    task automatic wait_drain(input string n);
        for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge CLK);
        @(negedge CLK);
        chk({n, "_drained"}, q.size(), 0);
        chk({n, "_level0"}, {29'd0, FIFO_LEVEL}, 0);
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        RESET = 1'b1; BUS_WE = 1'b0; BUS_ADDR = 8'h00; BUS_DATA = 8'h00; FB_READY = 1'b0;
        mx = 8'd0; my = 7'd0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        chk("rst_col", {16'd0, CONFIG_COL}, 32'hFF00);
        chk("rst_valid", {31'd0, FB_VALID}, 0);
        chk("rst_level", {29'd0, FIFO_LEVEL}, 0);
        chk("rst_ovf", {31'd0, OVERFLOW}, 0);
        chk("rst_addr", {17'd0, FB_ADDR}, 0);

        // Single pixel, visible right after the sampling edge
        FB_READY = 1'b1;
        wx(8'd5); wy(8'd3);
        q.push_back({15'h0305, 1'b1});
        wr(8'hB2, 8'd1);
        inc(1'b1);
        chk("single_valid", {31'd0, FB_VALID}, 1);
        wait_drain("single");

        // Backpressure: fifth write dropped, sticky overflow
        FB_READY = 1'b0;
        fill4();
        wx(8'd20);
        pix(1'b1, 1'b0);
        chk("bp_level", {29'd0, FIFO_LEVEL}, 4);
        chk("bp_ovf", {31'd0, OVERFLOW}, 1);
        FB_READY = 1'b1;
        wait_drain("bp");

        // Full FIFO plus simultaneous pop: push accepted
        FB_READY = 1'b0;
        fill4();
        @(posedge CLK); #1;
        FB_READY = 1'b1;
        q.push_back({my, mx, 1'b0});
        BUS_WE = 1'b1; BUS_ADDR = 8'hB2; BUS_DATA = 8'h00;
        @(posedge CLK); #1;
        BUS_WE = 1'b0;
        inc(1'b1);
        chk("fullpop_level", {29'd0, FIFO_LEVEL}, 4);
        chk("fullpop_ovf", {31'd0, OVERFLOW}, 1);
        wait_drain("fullpop");

        // Asynchronous reset while entries are queued
        FB_READY = 1'b0;
        fill4();
        chk("pre_rst_level", {29'd0, FIFO_LEVEL}, 4);
        #2 RESET = 1'b1;
        #1;
        chk("async_valid", {31'd0, FB_VALID}, 0);
        chk("async_level", {29'd0, FIFO_LEVEL}, 0);
        chk("async_addr", {17'd0, FB_ADDR}, 0);
        chk("async_ovf", {31'd0, OVERFLOW}, 0);
        q.delete();
        @(posedge CLK); #1;
        RESET = 1'b0;
        mx = 8'd0; my = 7'd0;

        // Out-of-range writes neither push nor set overflow, even when full
        fill4();
        chk("rng_full_level", {29'd0, FIFO_LEVEL}, 4);
        wx(8'd160);
        pix(1'b1, 1'b1);
        chk("rng_x_level", {29'd0, FIFO_LEVEL}, 4);
        chk("rng_x_ovf", {31'd0, OVERFLOW}, 0);
        wy(8'd120); wx(8'd5);
        pix(1'b1, 1'b1);
        chk("rng_y_ovf", {31'd0, OVERFLOW}, 0);
        FB_READY = 1'b1;
        wait_drain("rng");
        wy(8'd0); wx(8'd160);
        pix(1'b1, 1'b1);
        chk("rng_valid", {31'd0, FB_VALID}, 0);
        chk("rng_level", {29'd0, FIFO_LEVEL}, 0);

        // Colour registers and writes outside the window
        wr(8'hB3, 8'h1C);
        chk("col_lo", {16'd0, CONFIG_COL}, 32'hFF1C);
        wr(8'hB4, 8'hE0);
        chk("col_hi", {16'd0, CONFIG_COL}, 32'hE01C);
        wr(8'hB5, 8'h55);
        wr(8'hAF, 8'h66);
        chk("col_outside", {16'd0, CONFIG_COL}, 32'hE01C);

        // Last pixel of the frame, then the next write
        wx(8'd159); wy(8'd119);
        q.push_back({15'h779F, 1'b1});
        wr(8'hB2, 8'd1);
`ifdef VGA_BUS_AUTOINC_EN
        q.push_back({15'h0000, 1'b0});
`else
        q.push_back({15'h779F, 1'b0});
`endif
        wr(8'hB2, 8'd0);
        wait_drain("wrap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
